// File: rtl/ctrl_mmio_bridge.sv
// ctrl_mmio_bridge: turns single host MMIO read/write commands into AXI4
// single-beat transactions on the simulator ctrl slave port. One transaction
// is outstanding at a time; stale R/B beats with a foreign ID are drained.
// Optional watchdog: define CTRL_BRIDGE_TIMEOUT_EN to abort a transaction
// that waits TIMEOUT_CYCLES cycles on the AXI side (error response, sticky
// timeout_seen). Without the macro the bridge waits indefinitely.
//
// state   | meaning
// IDLE    | cmd_ready high, draining stray R/B beats
// RD_ADDR | AR valid, waiting for ar_ready
// RD_DATA | waiting for an R beat carrying the current ID
// WR_REQ  | AW and W valid, each dropped after its own handshake
// WR_RESP | waiting for a B beat carrying the current ID
// RESP    | rsp_valid held until rsp_ready
module ctrl_mmio_bridge #(
    parameter int unsigned ADDR_BITS      = 32,
    parameter int unsigned DATA_BITS      = 32,
    parameter int unsigned ID_BITS        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_BITS-1:0]   cmd_addr,
    input  logic [DATA_BITS-1:0]   cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_BITS-1:0]   rsp_rdata,
    output logic                   rsp_err,
    output logic                   ctrl_ar_valid,
    input  logic                   ctrl_ar_ready,
    output logic [ADDR_BITS-1:0]   ctrl_ar_bits_addr,
    output logic [ID_BITS-1:0]     ctrl_ar_bits_id,
    output logic [2:0]             ctrl_ar_bits_size,
    output logic [7:0]             ctrl_ar_bits_len,
    output logic                   ctrl_aw_valid,
    input  logic                   ctrl_aw_ready,
    output logic [ADDR_BITS-1:0]   ctrl_aw_bits_addr,
    output logic [ID_BITS-1:0]     ctrl_aw_bits_id,
    output logic [2:0]             ctrl_aw_bits_size,
    output logic [7:0]             ctrl_aw_bits_len,
    output logic                   ctrl_w_valid,
    input  logic                   ctrl_w_ready,
    output logic [DATA_BITS/8-1:0] ctrl_w_bits_strb,
    output logic [DATA_BITS-1:0]   ctrl_w_bits_data,
    output logic                   ctrl_w_bits_last,
    input  logic                   ctrl_r_valid,
    output logic                   ctrl_r_ready,
    input  logic [1:0]             ctrl_r_bits_resp,
    input  logic [ID_BITS-1:0]     ctrl_r_bits_id,
    input  logic [DATA_BITS-1:0]   ctrl_r_bits_data,
    input  logic                   ctrl_r_bits_last,
    input  logic                   ctrl_b_valid,
    output logic                   ctrl_b_ready,
    input  logic [1:0]             ctrl_b_bits_resp,
    input  logic [ID_BITS-1:0]     ctrl_b_bits_id,
    output logic                   timeout_seen
);
    localparam int unsigned STRB_BITS = DATA_BITS / 8;
    localparam logic [2:0]  AXI_SIZE  = 3'($clog2(STRB_BITS));

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

    state_t               state;
    logic                 live;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [ID_BITS-1:0]   id_ctr;
    logic [ID_BITS-1:0]   cur_id;
    logic                 aw_done;
    logic                 w_done;
    logic                 wd_expire;

    logic cmd_fire, ar_fire, aw_fire, w_fire, r_hit, b_hit;

    // live stays low until the first edge after reset release so cmd_ready
    // and the drain readies come up one cycle late.
    assign cmd_ready    = live && (state == IDLE);
    assign ctrl_r_ready = live && (state == IDLE || state == RD_DATA);
    assign ctrl_b_ready = live && (state == IDLE || state == WR_RESP);

    assign cmd_fire = cmd_valid && cmd_ready;
    assign ar_fire  = ctrl_ar_valid && ctrl_ar_ready;
    assign aw_fire  = ctrl_aw_valid && ctrl_aw_ready;
    assign w_fire   = ctrl_w_valid && ctrl_w_ready;
    assign r_hit    = ctrl_r_valid && ctrl_r_ready && (ctrl_r_bits_id == cur_id);
    assign b_hit    = ctrl_b_valid && ctrl_b_ready && (ctrl_b_bits_id == cur_id);

    assign ctrl_ar_bits_addr = addr_q;
    assign ctrl_ar_bits_id   = cur_id;
    assign ctrl_ar_bits_size = AXI_SIZE;
    assign ctrl_ar_bits_len  = 8'd0;
    assign ctrl_aw_bits_addr = addr_q;
    assign ctrl_aw_bits_id   = cur_id;
    assign ctrl_aw_bits_size = AXI_SIZE;
    assign ctrl_aw_bits_len  = 8'd0;
    assign ctrl_w_bits_strb  = '1;
    assign ctrl_w_bits_data  = wdata_q;
    assign ctrl_w_bits_last  = 1'b1;

`ifdef CTRL_BRIDGE_TIMEOUT_EN
    localparam int unsigned WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_BITS-1:0] wd_cnt;
    logic               wd_busy;

    assign wd_busy   = (state == RD_ADDR) || (state == RD_DATA) ||
                       (state == WR_REQ)  || (state == WR_RESP);
    assign wd_expire = wd_busy && (wd_cnt == WD_BITS'(TIMEOUT_CYCLES - 1));

    // Cycles spent waiting on the AXI side; restarts with each accepted command.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (cmd_fire) begin
            wd_cnt <= '0;
        end else if (wd_busy) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Sticky record that some transaction was aborted by the watchdog.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_seen <= 1'b0;
        end else if (wd_expire) begin
            timeout_seen <= 1'b1;
        end
    end

    logic unused_sigs;
    assign unused_sigs = &{1'b0, ctrl_r_bits_last, ctrl_r_bits_resp[0], ctrl_b_bits_resp[0]};
`else
    assign wd_expire    = 1'b0;
    assign timeout_seen = 1'b0;

    logic unused_sigs;
    assign unused_sigs = &{1'b0, ctrl_r_bits_last, ctrl_r_bits_resp[0], ctrl_b_bits_resp[0],
                           TIMEOUT_CYCLES[0]};
`endif

    // Transaction sequencer; a watchdog expiry overrides any pending handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            live          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            id_ctr        <= '0;
            cur_id        <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            ctrl_ar_valid <= 1'b0;
            ctrl_aw_valid <= 1'b0;
            ctrl_w_valid  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            live <= 1'b1;
            if (wd_expire) begin
                ctrl_ar_valid <= 1'b0;
                ctrl_aw_valid <= 1'b0;
                ctrl_w_valid  <= 1'b0;
                rsp_valid     <= 1'b1;
                rsp_rdata     <= '0;
                rsp_err       <= 1'b1;
                state         <= RESP;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_fire) begin
                            addr_q  <= cmd_addr;
                            wdata_q <= cmd_wdata;
                            cur_id  <= id_ctr;
                            id_ctr  <= id_ctr + 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            if (cmd_write) begin
                                ctrl_aw_valid <= 1'b1;
                                ctrl_w_valid  <= 1'b1;
                                state         <= WR_REQ;
                            end else begin
                                ctrl_ar_valid <= 1'b1;
                                state         <= RD_ADDR;
                            end
                        end
                    end
                    RD_ADDR: begin
                        if (ar_fire) begin
                            ctrl_ar_valid <= 1'b0;
                            state         <= RD_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (r_hit) begin
                            rsp_rdata <= ctrl_r_bits_data;
                            rsp_err   <= ctrl_r_bits_resp[1];
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                    WR_REQ: begin
                        if (aw_fire) begin
                            ctrl_aw_valid <= 1'b0;
                            aw_done       <= 1'b1;
                        end
                        if (w_fire) begin
                            ctrl_w_valid <= 1'b0;
                            w_done       <= 1'b1;
                        end
                        if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                            state <= WR_RESP;
                        end
                    end
                    WR_RESP: begin
                        if (b_hit) begin
                            rsp_rdata <= '0;
                            rsp_err   <= ctrl_b_bits_resp[1];
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                    RESP: begin
                        if (rsp_ready) begin
                            rsp_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ctrl_mmio_bridge.sv
// Directed bench for ctrl_mmio_bridge: a vector table of single transactions
// plus hand-written sequences for reset mid-transaction, ID wrap and the
// watchdog (or indefinite wait when the watchdog is not compiled in).
module tb_ctrl_mmio_bridge;
    localparam int ADDR_BITS      = 32;
    localparam int DATA_BITS      = 32;
    localparam int ID_BITS        = 4;
    localparam int TIMEOUT_CYCLES = 8;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [ADDR_BITS-1:0] cmd_addr = '0;
    logic [DATA_BITS-1:0] cmd_wdata = '0;
    logic                 rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [DATA_BITS-1:0] rsp_rdata;
    logic                 ctrl_ar_valid, ctrl_ar_ready = 1'b0;
    logic [ADDR_BITS-1:0] ctrl_ar_bits_addr;
    logic [ID_BITS-1:0]   ctrl_ar_bits_id;
    logic [2:0]           ctrl_ar_bits_size;
    logic [7:0]           ctrl_ar_bits_len;
    logic                 ctrl_aw_valid, ctrl_aw_ready = 1'b0;
    logic [ADDR_BITS-1:0] ctrl_aw_bits_addr;
    logic [ID_BITS-1:0]   ctrl_aw_bits_id;
    logic [2:0]           ctrl_aw_bits_size;
    logic [7:0]           ctrl_aw_bits_len;
    logic                 ctrl_w_valid, ctrl_w_ready = 1'b0;
    logic [3:0]           ctrl_w_bits_strb;
    logic [DATA_BITS-1:0] ctrl_w_bits_data;
    logic                 ctrl_w_bits_last;
    logic                 ctrl_r_valid = 1'b0, ctrl_r_ready;
    logic [1:0]           ctrl_r_bits_resp = '0;
    logic [ID_BITS-1:0]   ctrl_r_bits_id = '0;
    logic [DATA_BITS-1:0] ctrl_r_bits_data = '0;
    logic                 ctrl_r_bits_last = 1'b0;
    logic                 ctrl_b_valid = 1'b0, ctrl_b_ready;
    logic [1:0]           ctrl_b_bits_resp = '0;
    logic [ID_BITS-1:0]   ctrl_b_bits_id = '0;
    logic                 timeout_seen;

    int                   n_checks = 0;
    int                   n_fail = 0;
    logic [ID_BITS-1:0]   exp_id = '0;
    logic [ID_BITS-1:0]   txn_id = '0;
    logic [ID_BITS-1:0]   last_ar_id = '0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          aw_dly;
        int          w_dly;
        logic        bad_id;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    ctrl_mmio_bridge #(
        .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
        .ID_BITS(ID_BITS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ctrl_ar_valid(ctrl_ar_valid), .ctrl_ar_ready(ctrl_ar_ready),
        .ctrl_ar_bits_addr(ctrl_ar_bits_addr), .ctrl_ar_bits_id(ctrl_ar_bits_id),
        .ctrl_ar_bits_size(ctrl_ar_bits_size), .ctrl_ar_bits_len(ctrl_ar_bits_len),
        .ctrl_aw_valid(ctrl_aw_valid), .ctrl_aw_ready(ctrl_aw_ready),
        .ctrl_aw_bits_addr(ctrl_aw_bits_addr), .ctrl_aw_bits_id(ctrl_aw_bits_id),
        .ctrl_aw_bits_size(ctrl_aw_bits_size), .ctrl_aw_bits_len(ctrl_aw_bits_len),
        .ctrl_w_valid(ctrl_w_valid), .ctrl_w_ready(ctrl_w_ready),
        .ctrl_w_bits_strb(ctrl_w_bits_strb), .ctrl_w_bits_data(ctrl_w_bits_data),
        .ctrl_w_bits_last(ctrl_w_bits_last),
        .ctrl_r_valid(ctrl_r_valid), .ctrl_r_ready(ctrl_r_ready),
        .ctrl_r_bits_resp(ctrl_r_bits_resp), .ctrl_r_bits_id(ctrl_r_bits_id),
        .ctrl_r_bits_data(ctrl_r_bits_data), .ctrl_r_bits_last(ctrl_r_bits_last),
        .ctrl_b_valid(ctrl_b_valid), .ctrl_b_ready(ctrl_b_ready),
        .ctrl_b_bits_resp(ctrl_b_bits_resp), .ctrl_b_bits_id(ctrl_b_bits_id),
        .timeout_seen(timeout_seen)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic acc;
        acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = cmd_ready;
            step();
        end
        cmd_valid = 1'b0;
        check("cmd_accept", 64'(acc), 64'd1);
        txn_id = exp_id;
        exp_id = exp_id + 1'b1;
    endtask

    task automatic finish_rsp(input logic [31:0] exp_rdata, input logic exp_err);
        for (int t = 0; t < 20 && !rsp_valid; t++) step();
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        check("rsp_err", 64'(rsp_err), 64'(exp_err));
        step();
        check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
        check("rsp_hold_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        check("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_done", 64'(rsp_valid), 64'd0);
        check("cmd_ready_back", 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_read(input logic [31:0] a, input logic [31:0] rdata, input logic [1:0] resp,
                            input logic bad_id, input int hold,
                            input logic [31:0] exp_rdata, input logic exp_err);
        issue_cmd(1'b0, a, 32'h0);
        for (int t = 0; t < 20 && !ctrl_ar_valid; t++) step();
        check("ar_valid", 64'(ctrl_ar_valid), 64'd1);
        check("ar_addr", 64'(ctrl_ar_bits_addr), 64'(a));
        check("ar_id", 64'(ctrl_ar_bits_id), 64'(txn_id));
        check("ar_len", 64'(ctrl_ar_bits_len), 64'd0);
        check("ar_size", 64'(ctrl_ar_bits_size), 64'd2);
        last_ar_id = ctrl_ar_bits_id;
        ctrl_ar_ready = 1'b1;
        step();
        ctrl_ar_ready = 1'b0;
        check("ar_dropped", 64'(ctrl_ar_valid), 64'd0);
        if (hold > 0) begin
            repeat (hold) step();
            check("rd_wait_no_rsp", 64'(rsp_valid), 64'd0);
        end
        if (bad_id) begin
            ctrl_r_valid = 1'b1;
            ctrl_r_bits_id = txn_id + 1'b1;
            ctrl_r_bits_data = 32'h0BAD_0BAD;
            ctrl_r_bits_resp = 2'b00;
            check("r_ready_bad", 64'(ctrl_r_ready), 64'd1);
            step();
            check("bad_r_ignored", 64'(rsp_valid), 64'd0);
        end
        ctrl_r_valid = 1'b1;
        ctrl_r_bits_id = txn_id;
        ctrl_r_bits_data = rdata;
        ctrl_r_bits_resp = resp;
        ctrl_r_bits_last = 1'b1;
        check("r_ready", 64'(ctrl_r_ready), 64'd1);
        step();
        ctrl_r_valid = 1'b0;
        ctrl_r_bits_last = 1'b0;
        finish_rsp(exp_rdata, exp_err);
    endtask

    task automatic run_write(input logic [31:0] a, input logic [31:0] d, input int aw_dly, input int w_dly,
                             input logic [1:0] resp, input logic bad_id, input logic exp_err);
        int aw_at, w_at, n_aw, n_w, span;
        aw_at = -1; w_at = -1; n_aw = 0; n_w = 0;
        span = (aw_dly > w_dly) ? aw_dly : w_dly;
        issue_cmd(1'b1, a, d);
        check("aw_valid", 64'(ctrl_aw_valid), 64'd1);
        check("w_valid", 64'(ctrl_w_valid), 64'd1);
        check("aw_addr", 64'(ctrl_aw_bits_addr), 64'(a));
        check("aw_id", 64'(ctrl_aw_bits_id), 64'(txn_id));
        check("aw_len", 64'(ctrl_aw_bits_len), 64'd0);
        check("aw_size", 64'(ctrl_aw_bits_size), 64'd2);
        check("w_data", 64'(ctrl_w_bits_data), 64'(d));
        check("w_strb", 64'(ctrl_w_bits_strb), 64'hF);
        check("w_last", 64'(ctrl_w_bits_last), 64'd1);
        for (int c = 0; c <= span; c++) begin
            ctrl_aw_ready = (c >= aw_dly);
            ctrl_w_ready  = (c >= w_dly);
            if (ctrl_aw_valid && ctrl_aw_ready) begin
                n_aw++;
                if (aw_at < 0) aw_at = c;
            end
            if (ctrl_w_valid && ctrl_w_ready) begin
                n_w++;
                if (w_at < 0) w_at = c;
            end
            step();
        end
        ctrl_aw_ready = 1'b0;
        ctrl_w_ready = 1'b0;
        check("aw_fire_cycle", 64'(aw_at), 64'(aw_dly));
        check("w_fire_cycle", 64'(w_at), 64'(w_dly));
        check("aw_handshakes", 64'(n_aw), 64'd1);
        check("w_handshakes", 64'(n_w), 64'd1);
        check("aw_dropped", 64'(ctrl_aw_valid), 64'd0);
        check("w_dropped", 64'(ctrl_w_valid), 64'd0);
        if (bad_id) begin
            ctrl_b_valid = 1'b1;
            ctrl_b_bits_id = txn_id + 1'b1;
            ctrl_b_bits_resp = 2'b00;
            step();
            check("bad_b_ignored", 64'(rsp_valid), 64'd0);
        end
        ctrl_b_valid = 1'b1;
        ctrl_b_bits_id = txn_id;
        ctrl_b_bits_resp = resp;
        check("b_ready", 64'(ctrl_b_ready), 64'd1);
        step();
        ctrl_b_valid = 1'b0;
        finish_rsp(32'h0, exp_err);
    endtask

    initial begin
        //          wr    addr        data          resp   awd wd bad   exp_rdata     err
        vecs[0] = '{1'b0, 32'h10,  32'hDEADBEEF, 2'b00, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b1, 32'h20,  32'h12345678, 2'b00, 5, 0, 1'b0, 32'h0,        1'b0};
        vecs[2] = '{1'b1, 32'h24,  32'h55AA55AA, 2'b10, 0, 0, 1'b1, 32'h0,        1'b1};
        vecs[3] = '{1'b0, 32'h30,  32'hCAFEF00D, 2'b10, 0, 0, 1'b1, 32'hCAFEF00D, 1'b1};
        vecs[4] = '{1'b1, 32'h44,  32'hA5A5A5A5, 2'b01, 0, 3, 1'b0, 32'h0,        1'b0};
        vecs[5] = '{1'b0, 32'h48,  32'h01020304, 2'b01, 0, 0, 1'b0, 32'h01020304, 1'b0};

        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_ar_valid", 64'(ctrl_ar_valid), 64'd0);
        check("rst_aw_w_valid", 64'({ctrl_aw_valid, ctrl_w_valid}), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_timeout_seen", 64'(timeout_seen), 64'd0);
        #10 reset = 1'b1;
        #1 check("cmd_ready_pre_edge", 64'(cmd_ready), 64'd0);
        step();
        check("cmd_ready_after_edge", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr)
                run_write(vecs[i].addr, vecs[i].data, vecs[i].aw_dly, vecs[i].w_dly,
                          vecs[i].resp, vecs[i].bad_id, vecs[i].exp_err);
            else
                run_read(vecs[i].addr, vecs[i].data, vecs[i].resp, vecs[i].bad_id, 0,
                         vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Reset while a write has AW/W up: valids must drop without a clock edge.
        issue_cmd(1'b1, 32'h60, 32'h0);
        #3 reset = 1'b0;
        #1;
        check("async_rst_aw_w", 64'({ctrl_aw_valid, ctrl_w_valid}), 64'd0);
        check("async_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        step();
        reset = 1'b1;
        step();

        // Reset while waiting in RD_DATA: no response may ever appear.
        issue_cmd(1'b0, 32'h40, 32'h0);
        ctrl_ar_ready = 1'b1;
        step();
        ctrl_ar_ready = 1'b0;
        check("rd_data_reached", 64'(ctrl_r_ready), 64'd1);
        #3 reset = 1'b0;
        #1;
        check("async_rst_valids",
              64'({ctrl_ar_valid, ctrl_aw_valid, ctrl_w_valid, rsp_valid}), 64'd0);
        check("async_rst_r_ready", 64'(ctrl_r_ready), 64'd0);
        exp_id = '0;
        step();
        step();
        check("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
        reset = 1'b1;
        #1 check("rel_cmd_ready_low", 64'(cmd_ready), 64'd0);
        step();
        check("rel_cmd_ready_high", 64'(cmd_ready), 64'd1);
        check("no_rsp_after_rel", 64'(rsp_valid), 64'd0);

        // 17 reads after reset: IDs 0..15 then wrap to 0.
        for (int i = 0; i < 17; i++) begin
            run_read(32'h100 + 32'(i * 4), 32'hB000_0000 + 32'(i), 2'b00, 1'b0, 0,
                     32'hB000_0000 + 32'(i), 1'b0);
            check("id_sweep", 64'(last_ar_id), 64'(i % 16));
        end

`ifdef CTRL_BRIDGE_TIMEOUT_EN
        begin
            int edges;
            issue_cmd(1'b0, 32'h80, 32'h0);
            ctrl_ar_ready = 1'b1;
            step();
            ctrl_ar_ready = 1'b0;
            edges = 1;
            while (!rsp_valid && edges < 40) begin
                step();
                edges++;
            end
            check("timeout_cycles", 64'(edges), 64'd8);
            check("timeout_rsp_err", 64'(rsp_err), 64'd1);
            check("timeout_rsp_rdata", 64'(rsp_rdata), 64'd0);
            check("timeout_seen_set", 64'(timeout_seen), 64'd1);
            check("timeout_ar_low", 64'(ctrl_ar_valid), 64'd0);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            check("timeout_back_idle", 64'(cmd_ready), 64'd1);
            ctrl_r_valid = 1'b1;
            ctrl_r_bits_id = txn_id;
            ctrl_r_bits_data = 32'hFEEDFACE;
            check("late_r_drained", 64'(ctrl_r_ready), 64'd1);
            step();
            ctrl_r_valid = 1'b0;
            check("late_r_no_rsp", 64'(rsp_valid), 64'd0);
            check("late_r_still_idle", 64'(cmd_ready), 64'd1);
            run_read(32'h84, 32'h13572468, 2'b00, 1'b0, 0, 32'h13572468, 1'b0);
            check("timeout_sticky", 64'(timeout_seen), 64'd1);
            #3 reset = 1'b0;
            #1 check("timeout_seen_cleared", 64'(timeout_seen), 64'd0);
            reset = 1'b1;
            step();
        end
`else
        run_read(32'h90, 32'h2468ACE0, 2'b00, 1'b0, 30, 32'h2468ACE0, 1'b0);
        check("timeout_seen_tied", 64'(timeout_seen), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule
